// File: rtl/fifo_bist_pkg.sv
// Shared types and constants for the FIFO built-in self-test block.
package fifo_bist_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM     = 2'd0,
        MODE_FILL_DRAIN = 2'd1,
        MODE_THROTTLE   = 2'd2,
        MODE_RSVD       = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RUN,
        FINISH
    } state_e;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/fifo_bist_lfsr16.sv
// 16-bit maximal-length LFSR used to throttle the BIST write/read strobes.
module bist_lfsr16
    import fifo_bist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        load_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = LFSR_SEED;
        end else if (enable_i) begin
            state_d = lfsrNext(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/fifo_bist.sv
// Self-test traffic generator and checker for an external FIFO: writes an incrementing
// word sequence, reads it back, counts mismatches and aborts on a stalled FIFO.
module fifo_bist
    import fifo_bist_pkg::*;
#(
    parameter int DW      = 24,
    parameter int NWORDS  = 256,
    parameter int SEED    = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [DW-1:0] wdata,
    output logic          winc,
    input  logic          wfull,
    input  logic [DW-1:0] rdata,
    output logic          rinc,
    input  logic          rempty,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_cnt
);

    localparam int CW  = $clog2(NWORDS + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  NWORDS_C  = CW'(NWORDS);
    localparam logic [WDW-1:0] TIMEOUT_C = WDW'(TIMEOUT);
    localparam logic [DW-1:0]  SEED_C    = DW'(SEED);

    state_e         state_q,   state_d;
    mode_e          mode_q,    mode_d;
    logic [CW-1:0]  wrCnt_q,   wrCnt_d;
    logic [CW-1:0]  rdCnt_q,   rdCnt_d;
    logic [DW-1:0]  wdata_q,   wdata_d;
    logic [DW-1:0]  expData_q, expData_d;
    logic           rdValid_q, rdValid_d;
    logic [15:0]    errCnt_q,  errCnt_d;
    logic [WDW-1:0] idleCnt_q, idleCnt_d;
    logic           done_q,    done_d;
    logic           pass_q,    pass_d;
    logic           timeout_q, timeout_d;

    logic        wincInt;
    logic        rincInt;
    logic        lfsrLoad;
    logic [15:0] lfsrState;
    logic        unusedLfsrBits;
    logic        busyInt;
    logic        canWrite;
    logic        canRead;
    logic        readsDone;
    logic        throttle;
    logic        startAccept;

    assign busyInt     = (state_q == WRITE) || (state_q == READ) || (state_q == RUN);
    assign canWrite    = !wfull && (wrCnt_q != NWORDS_C);
    assign canRead     = !rempty && (rdCnt_q != NWORDS_C);
    assign readsDone   = (rdCnt_q == NWORDS_C);
    assign throttle    = (mode_q == MODE_THROTTLE);
    assign startAccept = start && ((state_q == IDLE) || (state_q == FINISH));

    bist_lfsr16 uLfsr (
        .clk_i    (CLK),
        .rst_i    (RST),
        .enable_i (busyInt),
        .load_i   (lfsrLoad),
        .state_o  (lfsrState)
    );

    assign unusedLfsrBits = ^lfsrState[15:2];

    // Strobe generation, read-back checking and the watchdog; an accepted start overrides all
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wrCnt_d   = wrCnt_q;
        rdCnt_d   = rdCnt_q;
        wdata_d   = wdata_q;
        expData_d = expData_q;
        rdValid_d = 1'b0;
        errCnt_d  = errCnt_q;
        idleCnt_d = idleCnt_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        wincInt   = 1'b0;
        rincInt   = 1'b0;
        lfsrLoad  = 1'b0;

        case (state_q)
            RUN: begin
                wincInt = canWrite && (!throttle || lfsrState[0]);
                rincInt = canRead && (!throttle || lfsrState[1]);
            end
            WRITE: begin
                wincInt = canWrite;
                if (!canWrite) begin
                    state_d = READ;
                end
            end
            READ: begin
                rincInt = canRead;
                if (!canRead && !readsDone) begin
                    state_d = WRITE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
            end
        endcase

        if (wincInt) begin
            wrCnt_d = wrCnt_q + 1'b1;
            wdata_d = wdata_q + 1'b1;
        end
        if (rincInt) begin
            rdCnt_d = rdCnt_q + 1'b1;
        end
        rdValid_d = rincInt;

        // Read data lands one cycle after rinc, so the check trails the strobe
        if (rdValid_q) begin
            expData_d = expData_q + 1'b1;
            if ((rdata != expData_q) && (errCnt_q != 16'hFFFF)) begin
                errCnt_d = errCnt_q + 1'b1;
            end
        end

        if (busyInt) begin
            if (wincInt || rincInt) begin
                idleCnt_d = '0;
            end else begin
                idleCnt_d = idleCnt_q + 1'b1;
            end
            if (idleCnt_d == TIMEOUT_C) begin
                timeout_d = 1'b1;
                pass_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = FINISH;
            end else if (rdValid_q && readsDone) begin
                pass_d  = (errCnt_d == 16'h0000);
                done_d  = 1'b1;
                state_d = FINISH;
            end
        end

        if (startAccept) begin
            mode_d    = mode_e'(mode);
            state_d   = (mode_e'(mode) == MODE_FILL_DRAIN) ? WRITE : RUN;
            wrCnt_d   = '0;
            rdCnt_d   = '0;
            wdata_d   = SEED_C;
            expData_d = SEED_C;
            rdValid_d = 1'b0;
            errCnt_d  = '0;
            idleCnt_d = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            lfsrLoad  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            mode_q    <= MODE_STREAM;
            wrCnt_q   <= '0;
            rdCnt_q   <= '0;
            wdata_q   <= SEED_C;
            expData_q <= SEED_C;
            rdValid_q <= 1'b0;
            errCnt_q  <= '0;
            idleCnt_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wrCnt_q   <= wrCnt_d;
            rdCnt_q   <= rdCnt_d;
            wdata_q   <= wdata_d;
            expData_q <= expData_d;
            rdValid_q <= rdValid_d;
            errCnt_q  <= errCnt_d;
            idleCnt_q <= idleCnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign wdata   = wdata_q;
    assign winc    = wincInt;
    assign rinc    = rincInt;
    assign busy    = busyInt;
    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;
    assign err_cnt = errCnt_q;

endmodule
